// File: rtl/tictactoe_pkg.sv
// Shared types and helpers for the tic-tac-toe controller and its board evaluator.
// Cells are numbered 0..8 row-major; bit i of a board is cell i.
package tictactoe_pkg;

  localparam int CELLS = 9;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_X,
    WAIT_O,
    CHECK,
    DONE
  } state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_X    = 2'b01;
  localparam logic [1:0] RES_O    = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  // True when the board holds any complete row, column or diagonal.
  function automatic logic has_line(input logic [CELLS-1:0] b);
    has_line = (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  // One-hot cell mask; an out-of-range index yields an empty mask.
  function automatic logic [CELLS-1:0] cell_mask(input logic [3:0] pos);
    cell_mask = '0;
    if (pos < 4'(CELLS)) cell_mask = {{(CELLS-1){1'b0}}, 1'b1} << pos;
  endfunction

endpackage

// File: rtl/tictactoe.sv
// Combinational board evaluator: win detection per player, board-full and
// overlap (both players claiming one cell) flags.
module tictactoe
  import tictactoe_pkg::*;
(
  input  logic [CELLS-1:0] x,
  input  logic [CELLS-1:0] o,
  output logic             winX,
  output logic             winO,
  output logic             full,
  output logic             error
);

  assign winX  = has_line(x);
  assign winO  = has_line(o);
  assign full  = &(x | o);
  assign error = |(x & o);

endmodule

// File: rtl/tictactoe_ctrl.sv
// Tic-tac-toe game controller: board registers, req/ack turn handshake,
// illegal-move rejection, per-turn inactivity timeout and result latching.
module tictactoe_ctrl
  import tictactoe_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             x_req,
  input  logic [3:0]       x_pos,
  output logic             x_ack,
  input  logic             o_req,
  input  logic [3:0]       o_pos,
  output logic             o_ack,
  output logic [CELLS-1:0] x_board,
  output logic [CELLS-1:0] o_board,
  output logic             turn,
  output logic             illegal,
  output logic             timeout,
  output logic             game_over,
  output logic [1:0]       result,
  output logic             fault
);

  // A zero TIMEOUT still needs a legal one-bit counter.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t           state, state_nxt;
  logic [CELLS-1:0] x_board_nxt, o_board_nxt;
  logic             turn_nxt, x_ack_nxt, o_ack_nxt, illegal_nxt, timeout_nxt, fault_nxt;
  logic [1:0]       result_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  logic             ev_winx, ev_wino, ev_full, ev_error;
  logic             mv_o, mv_req, mv_legal, tmo_hit;
  logic [3:0]       mv_pos;
  logic [CELLS-1:0] mv_mask;

  tictactoe u_eval (
    .x     (x_board),
    .o     (o_board),
    .winX  (ev_winx),
    .winO  (ev_wino),
    .full  (ev_full),
    .error (ev_error)
  );

  // Only the player whose WAIT state is active is ever looked at.
  assign mv_o     = (state == WAIT_O);
  assign mv_req   = mv_o ? o_req : x_req;
  assign mv_pos   = mv_o ? o_pos : x_pos;
  assign mv_mask  = cell_mask(mv_pos);
  assign mv_legal = mv_req && (|mv_mask) && !(|(mv_mask & (x_board | o_board)));
  assign tmo_hit  = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  assign game_over = (state == DONE);

  always_comb begin
    state_nxt   = state;
    x_board_nxt = x_board;
    o_board_nxt = o_board;
    turn_nxt    = turn;
    result_nxt  = result;
    fault_nxt   = fault;
    cnt_nxt     = cnt;
    x_ack_nxt   = 1'b0;
    o_ack_nxt   = 1'b0;
    illegal_nxt = 1'b0;
    timeout_nxt = 1'b0;

    case (state)
      IDLE: ;
      WAIT_X, WAIT_O: begin
        if (mv_legal) begin
          if (mv_o) begin
            o_board_nxt = o_board | mv_mask;
            o_ack_nxt   = 1'b1;
          end else begin
            x_board_nxt = x_board | mv_mask;
            x_ack_nxt   = 1'b1;
          end
          state_nxt = CHECK;
        end else begin
          illegal_nxt = mv_req;
          if (tmo_hit) begin
            timeout_nxt = 1'b1;
            turn_nxt    = ~turn;
            state_nxt   = mv_o ? WAIT_X : WAIT_O;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      // Ack stays high here; the evaluator sees the freshly updated boards.
      CHECK: begin
        if (ev_error) begin
          fault_nxt  = 1'b1;
          result_nxt = RES_NONE;
          state_nxt  = DONE;
        end else if (ev_winx) begin
          result_nxt = RES_X;
          state_nxt  = DONE;
        end else if (ev_wino) begin
          result_nxt = RES_O;
          state_nxt  = DONE;
        end else if (ev_full) begin
          result_nxt = RES_DRAW;
          state_nxt  = DONE;
        end else begin
          turn_nxt  = ~turn;
          state_nxt = turn ? WAIT_X : WAIT_O;
          cnt_nxt   = '0;
        end
      end
      DONE: ;
      default: state_nxt = IDLE;
    endcase

    if (start) begin
      state_nxt   = WAIT_X;
      x_board_nxt = '0;
      o_board_nxt = '0;
      turn_nxt    = 1'b0;
      result_nxt  = RES_NONE;
      fault_nxt   = 1'b0;
      cnt_nxt     = '0;
      x_ack_nxt   = 1'b0;
      o_ack_nxt   = 1'b0;
      illegal_nxt = 1'b0;
      timeout_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      x_board <= '0;
      o_board <= '0;
      turn    <= 1'b0;
      result  <= RES_NONE;
      fault   <= 1'b0;
      cnt     <= '0;
      x_ack   <= 1'b0;
      o_ack   <= 1'b0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      x_board <= x_board_nxt;
      o_board <= o_board_nxt;
      turn    <= turn_nxt;
      result  <= result_nxt;
      fault   <= fault_nxt;
      cnt     <= cnt_nxt;
      x_ack   <= x_ack_nxt;
      o_ack   <= o_ack_nxt;
      illegal <= illegal_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_tictactoe_ctrl.sv
// Bench for tictactoe_ctrl: every ack/illegal/timeout pulse is matched against
// an expectation queued when the stimulus was driven.
module tb_tictactoe_ctrl;
  import tictactoe_pkg::*;

  localparam int TMO     = 3;
  localparam int EV_XACK = 1;
  localparam int EV_OACK = 2;
  localparam int EV_ILL  = 3;
  localparam int EV_TMO  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       x_req = 1'b0, o_req = 1'b0;
  logic [3:0] x_pos = '0, o_pos = '0;
  logic       x_ack, o_ack, turn, illegal, timeout, game_over, fault;
  logic [8:0] x_board, o_board;
  logic [1:0] result;

  typedef struct {
    int         kind;
    logic [8:0] xb;
    logic [8:0] ob;
    logic       trn;
  } exp_t;

  exp_t       sbq[$];
  int         nchk = 0;
  int         npass = 0;
  int         xacks = 0;
  logic [8:0] mxb = '0, mob = '0;
  logic       mturn = 1'b0;

  always #5 clk = ~clk;

  tictactoe_ctrl #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_req     (x_req),
    .x_pos     (x_pos),
    .x_ack     (x_ack),
    .o_req     (o_req),
    .o_pos     (o_pos),
    .o_ack     (o_ack),
    .x_board   (x_board),
    .o_board   (o_board),
    .turn      (turn),
    .illegal   (illegal),
    .timeout   (timeout),
    .game_over (game_over),
    .result    (result),
    .fault     (fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic observe(input int kind);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_unexpected_event", kind, 0);
    end else begin
      e = sbq.pop_front();
      chk("sb_kind", kind, e.kind);
      chk("sb_x_board", {23'd0, x_board}, {23'd0, e.xb});
      chk("sb_o_board", {23'd0, o_board}, {23'd0, e.ob});
      chk("sb_turn", {31'd0, turn}, {31'd0, e.trn});
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (x_ack === 1'b1) begin
        xacks++;
        observe(EV_XACK);
      end
      if (o_ack === 1'b1) observe(EV_OACK);
      if (illegal === 1'b1) observe(EV_ILL);
      if (timeout === 1'b1) observe(EV_TMO);
    end
  end

  // Called at a falling edge; leaves the game in WAIT_X at the next falling edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mxb   = '0;
    mob   = '0;
    mturn = 1'b0;
  endtask

  // One request held for exactly one sampling edge; after a legal move the
  // extra cycle covers CHECK so the next player starts in its WAIT state.
  task automatic move(input logic player, input logic [3:0] pos);
    logic       legal;
    logic [8:0] occ;
    exp_t       e;
    occ   = mxb | mob;
    legal = 1'b0;
    if (pos <= 4'd8) legal = !occ[pos];
    if (legal) begin
      if (player) mob[pos] = 1'b1;
      else        mxb[pos] = 1'b1;
      e = '{player ? EV_OACK : EV_XACK, mxb, mob, mturn};
      mturn = ~mturn;
    end else begin
      e = '{EV_ILL, mxb, mob, mturn};
    end
    sbq.push_back(e);
    if (player) begin
      o_req = 1'b1;
      o_pos = pos;
    end else begin
      x_req = 1'b1;
      x_pos = pos;
    end
    @(negedge clk);
    x_req = 1'b0;
    o_req = 1'b0;
    if (legal) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    chk("rst_x_board", {23'd0, x_board}, 0);
    chk("rst_o_board", {23'd0, o_board}, 0);
    chk("rst_turn", {31'd0, turn}, 0);
    chk("rst_result", {30'd0, result}, 0);
    chk("rst_game_over", {31'd0, game_over}, 0);
    chk("rst_pulses", {28'd0, x_ack, o_ack, illegal, timeout}, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    rst = 1'b0;

    // IDLE ignores requests
    x_req = 1'b1;
    x_pos = 4'd0;
    repeat (2) @(negedge clk);
    x_req = 1'b0;
    chk("idle_ignore", {23'd0, x_board}, 0);

    // X wins along the top row
    xacks = 0;
    do_start();
    move(1'b0, 4'd0);
    move(1'b1, 4'd3);
    move(1'b0, 4'd1);
    move(1'b1, 4'd4);
    move(1'b0, 4'd2);
    chk("win_x_board", {23'd0, x_board}, 32'h007);
    chk("win_o_board", {23'd0, o_board}, 32'h018);
    chk("win_result", {30'd0, result}, {30'd0, RES_X});
    chk("win_game_over", {31'd0, game_over}, 1);
    chk("win_fault", {31'd0, fault}, 0);
    chk("win_x_acks", xacks, 3);

    // DONE holds and ignores requests
    x_req = 1'b1;
    x_pos = 4'd5;
    repeat (3) @(negedge clk);
    x_req = 1'b0;
    chk("done_hold_board", {23'd0, x_board}, 32'h007);
    chk("done_hold_over", {31'd0, game_over}, 1);

    // Draw
    do_start();
    chk("start_clears_over", {31'd0, game_over}, 0);
    chk("start_clears_result", {30'd0, result}, 0);
    chk("start_clears_board", {23'd0, x_board}, 0);
    move(1'b0, 4'd4);
    move(1'b1, 4'd8);
    move(1'b0, 4'd0);
    move(1'b1, 4'd3);
    move(1'b0, 4'd5);
    move(1'b1, 4'd2);
    move(1'b0, 4'd7);
    move(1'b1, 4'd1);
    move(1'b0, 4'd6);
    chk("draw_result", {30'd0, result}, {30'd0, RES_DRAW});
    chk("draw_o_board", {23'd0, o_board}, 32'h10E);
    chk("draw_x_board", {23'd0, x_board}, {23'd0, mxb});
    chk("draw_game_over", {31'd0, game_over}, 1);

    // Illegal requests by O; the last legal one lands on the timeout cycle
    do_start();
    move(1'b0, 4'd4);
    move(1'b1, 4'd4);
    move(1'b1, 4'd9);
    chk("ill_turn", {31'd0, turn}, 1);
    chk("ill_o_board", {23'd0, o_board}, 0);
    move(1'b1, 4'd0);
    chk("ill_then_legal_turn", {31'd0, turn}, 0);
    chk("ill_then_legal_board", {23'd0, o_board}, 32'h001);

    // Timeout while X idles, then simultaneous requests
    do_start();
    e = '{EV_TMO, 9'h000, 9'h000, 1'b1};
    sbq.push_back(e);
    mturn = 1'b1;
    repeat (2) @(negedge clk);
    chk("tmo_early", {31'd0, timeout}, 0);
    @(negedge clk);
    chk("tmo_pulse", {31'd0, timeout}, 1);
    chk("tmo_turn", {31'd0, turn}, 1);
    mob[4] = 1'b1;
    e = '{EV_OACK, 9'h000, 9'h010, 1'b1};
    sbq.push_back(e);
    o_req = 1'b1;
    o_pos = 4'd4;
    x_req = 1'b1;
    x_pos = 4'd5;
    @(negedge clk);
    o_req = 1'b0;
    x_req = 1'b0;
    @(negedge clk);
    mturn = 1'b0;
    chk("both_req_x_board", {23'd0, x_board}, 0);
    chk("both_req_turn", {31'd0, turn}, 0);

    // start beats a simultaneous legal request
    move(1'b0, 4'd8);
    move(1'b1, 4'd3);
    start = 1'b1;
    x_req = 1'b1;
    x_pos = 4'd0;
    @(negedge clk);
    start = 1'b0;
    x_req = 1'b0;
    mxb   = '0;
    mob   = '0;
    mturn = 1'b0;
    chk("start_req_x_board", {23'd0, x_board}, 0);
    chk("start_req_o_board", {23'd0, o_board}, 0);
    chk("start_req_turn", {31'd0, turn}, 0);
    chk("start_req_no_ack", {31'd0, x_ack}, 0);
    move(1'b0, 4'd0);

    // Asynchronous reset during CHECK
    o_req = 1'b1;
    o_pos = 4'd2;
    @(posedge clk);
    #1;
    o_req = 1'b0;
    chk("pre_rst_o_ack", {31'd0, o_ack}, 1);
    chk("pre_rst_o_board", {23'd0, o_board}, 32'h004);
    #1 rst = 1'b1;
    #1;
    chk("arst_boards", {14'd0, x_board, o_board}, 0);
    chk("arst_pulses", {28'd0, x_ack, o_ack, illegal, timeout}, 0);
    chk("arst_status", {27'd0, turn, game_over, result, fault}, 0);
    @(negedge clk);
    rst = 1'b0;
    x_req = 1'b1;
    x_pos = 4'd0;
    repeat (2) @(negedge clk);
    x_req = 1'b0;
    chk("post_rst_idle", {23'd0, x_board}, 0);

    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
